// File: rtl/tspi_xfer_ctrl.sv
// TSPI transfer sequencer: shifts one command out through the TSPI shift register,
// optionally collects a slave response, and hands the result back on a valid/ready port.
module tspi_xfer_ctrl #(
   parameter int DivW = 8,
   parameter int ToW  = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [DivW-1:0] clk_div_i,
   input  logic [ToW-1:0]  timeout_i,
   input  logic            abort_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [31:0]     req_data_i,
   input  logic [5:0]      req_len_i,
   input  logic            req_resp_i,
   input  logic [5:0]      req_resp_len_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [31:0]     rsp_data_o,
   output logic            rsp_timeout_o,
   output logic            busy_o,
   output logic            tspi_clk_o,
   output logic [5:0]      len_cmd_o,
   output logic            new_cmd_o,
   output logic            en_write_o,
   output logic [31:0]     cmd_data_o,
   input  logic            start_bit_i,
   input  logic [31:0]     shift_data_i
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] SEND       = 3'd1;
   localparam logic [2:0] WAIT_START = 3'd2;
   localparam logic [2:0] RECV       = 3'd3;
   localparam logic [2:0] DONE       = 3'd4;

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic [DivW-1:0] div_cnt;
   logic [DivW-1:0] div_lat;
   logic [ToW-1:0]  to_cnt;
   logic [ToW-1:0]  to_inc;
   logic [ToW-1:0]  to_lat;
   logic            lead;
   logic            tspi_clk;
   logic            tspi_prev;
   logic [5:0]      bit_cnt;
   logic [5:0]      len_lat;
   logic [5:0]      resp_len_lat;
   logic            resp_lat;
   logic            timed_out;
   logic [31:0]     data_lat;
   logic [31:0]     rsp_data;
   logic [31:0]     resp_mask;
   logic            rsp_valid;
   logic            rsp_timeout;
   logic            rise;
   logic            accept;
   logic            running_nxt;
   logic            wait_expired;

   assign rise         = tspi_clk & ~tspi_prev;
   assign accept       = (state == IDLE) && req_valid_i && !abort_i;
   assign to_inc       = to_cnt + ToW'(1);
   assign wait_expired = (to_lat != '0) && (to_inc == to_lat);
   assign resp_mask    = 32'hFFFF_FFFF >> (5'd31 - resp_len_lat[4:0]);
   assign running_nxt  = (state_nxt == SEND) || (state_nxt == WAIT_START) || (state_nxt == RECV);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (accept) state_nxt = SEND;
         SEND:       if (rise && (bit_cnt == len_lat)) state_nxt = resp_lat ? WAIT_START : DONE;
         WAIT_START: begin
            if (rise) begin
               if (start_bit_i) state_nxt = RECV;
               else if (wait_expired) state_nxt = DONE;
            end
         end
         RECV:       if (rise && (bit_cnt == resp_len_lat)) state_nxt = DONE;
         DONE:       if (rsp_valid && rsp_ready_i) state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      if (abort_i) state_nxt = IDLE;
   end

   // The accept cycle counts as the first cycle of a leading low half-period, so the
   // first toggle after accept is swallowed and the first rise lands 2*(div+1) cycles out.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_cnt   <= '0;
         lead      <= 1'b0;
         tspi_clk  <= 1'b0;
         tspi_prev <= 1'b0;
      end else begin
         tspi_prev <= tspi_clk;
         if (accept) begin
            div_cnt  <= (clk_div_i == '0) ? '0 : DivW'(1);
            lead     <= (clk_div_i != '0);
            tspi_clk <= 1'b0;
         end else if (!running_nxt) begin
            div_cnt  <= '0;
            lead     <= 1'b0;
            tspi_clk <= 1'b0;
         end else if (div_cnt == div_lat) begin
            div_cnt <= '0;
            if (lead) lead <= 1'b0;
            else tspi_clk <= ~tspi_clk;
         end else begin
            div_cnt <= div_cnt + DivW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         div_lat      <= '0;
         to_lat       <= '0;
         to_cnt       <= '0;
         bit_cnt      <= '0;
         len_lat      <= '0;
         resp_len_lat <= '0;
         resp_lat     <= 1'b0;
         timed_out    <= 1'b0;
         data_lat     <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_timeout  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (abort_i) begin
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (req_valid_i) begin
                     div_lat      <= clk_div_i;
                     to_lat       <= timeout_i;
                     data_lat     <= req_data_i;
                     len_lat      <= req_len_i;
                     resp_lat     <= req_resp_i;
                     resp_len_lat <= req_resp_len_i;
                     bit_cnt      <= '0;
                     to_cnt       <= '0;
                     timed_out    <= 1'b0;
                  end
               end
               SEND: begin
                  if (rise) bit_cnt <= bit_cnt + 6'd1;
               end
               WAIT_START: begin
                  if (rise) begin
                     if (start_bit_i) begin
                        bit_cnt <= '0;
                     end else begin
                        to_cnt <= to_inc;
                        if (wait_expired) timed_out <= 1'b1;
                     end
                  end
               end
               RECV: begin
                  if (rise) bit_cnt <= bit_cnt + 6'd1;
               end
               DONE: begin
                  // shift_data_i settles one cycle after the last rise, i.e. now
                  if (!rsp_valid) begin
                     rsp_valid   <= 1'b1;
                     rsp_timeout <= timed_out;
                     rsp_data    <= (resp_lat && !timed_out) ? (shift_data_i & resp_mask) : '0;
                  end else if (rsp_ready_i) begin
                     rsp_valid   <= 1'b0;
                     rsp_data    <= '0;
                     rsp_timeout <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign req_ready_o   = (state == IDLE);
   assign busy_o        = (state != IDLE);
   assign tspi_clk_o    = tspi_clk;
   assign len_cmd_o     = len_lat;
   assign new_cmd_o     = (state == SEND) && (bit_cnt == 6'd0);
   assign en_write_o    = (state == SEND);
   assign cmd_data_o    = data_lat;
   assign rsp_valid_o   = rsp_valid;
   assign rsp_data_o    = rsp_data;
   assign rsp_timeout_o = rsp_timeout;

endmodule
